// File: rtl/slide_engine_if.sv
// Request/result bundle between a move-order source and the slide engine.
// No latency of its own; plain wires.
// No backpressure: start is a one-cycle request, results are pulses and held flags.
interface slide_engine_if;
  logic        start;
  logic [39:0] board_in;
  logic [33:0] ord_in;
  logic        busy;
  logic        done;
  logic        err;
  logic        hit;
  logic        wb_we;
  logic [3:0]  wb_dst;
  logic [39:0] wb_data;

  modport master (
    output start, board_in, ord_in,
    input  busy, done, err, hit, wb_we, wb_dst, wb_data
  );

  modport slave (
    input  start, board_in, ord_in,
    output busy, done, err, hit, wb_we, wb_dst, wb_data
  );
endinterface

// File: rtl/slide_engine.sv
// 8-puzzle move executor: applies up to 15 blank moves, writes the board back, flags err/hit.
// Latency: d moves take d cycles, then one WRITE cycle and one DONE cycle.
// No backpressure: start is ignored while busy; the write port cannot stall.
module slide_engine #(
  parameter logic [3:0]  DST_REG = 4'd2,
  parameter logic [39:0] GOAL    = 40'h8123456780
) (
  input  logic          clk,
  input  logic          rst_n,
  slide_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [39:0] board_q, board_d;
  logic [33:0] ord_q, ord_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        hit_q, hit_d;

  logic [3:0]  blank;
  logic [3:0]  depth;
  logic [3:0]  col;
  logic [1:0]  mv;
  logic        legal;
  logic [3:0]  nb;
  logic [3:0]  tile;
  logic [39:0] moved;

  assign blank = board_q[39:36];
  assign depth = ord_q[33:30];
  assign col   = blank % 4'd3;

  // Decode the current move and the blank's destination, then build the post-move board.
  always_comb begin
    mv    = 2'b00;
    legal = 1'b0;
    nb    = blank;
    tile  = 4'h0;
    moved = board_q;
    for (int k = 0; k < 15; k++) begin
      if (cnt_q == 4'(k)) mv = ord_q[29-2*k -: 2];
    end
    case (mv)
      2'b00: begin legal = (blank >= 4'd3);  nb = blank - 4'd3; end
      2'b01: begin legal = (blank <= 4'd5);  nb = blank + 4'd3; end
      2'b10: begin legal = (col != 4'd0);    nb = blank - 4'd1; end
      default: begin legal = (col != 4'd2);  nb = blank + 4'd1; end
    endcase
    for (int i = 0; i < 9; i++) begin
      if (nb == 4'(i)) tile = board_q[35-4*i -: 4];
    end
    moved[39:36] = nb;
    for (int i = 0; i < 9; i++) begin
      if (blank == 4'(i)) moved[35-4*i -: 4] = tile;
      if (nb == 4'(i))    moved[35-4*i -: 4] = 4'h0;
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/WRITE/DONE sequence.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    ord_d   = ord_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hit_d   = hit_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          board_d = bus.board_in;
          ord_d   = bus.ord_in;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          hit_d   = 1'b0;
          if (bus.board_in[39:36] > 4'd8) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (bus.ord_in[33:30] == 4'd0) begin
            state_d = WRITE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!legal) begin
          // Board is frozen at the last legal position; no write-back for this run.
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          board_d = moved;
          cnt_d   = cnt_q + 4'd1;
          if (({1'b0, cnt_q} + 5'd1) == {1'b0, depth}) state_d = WRITE;
        end
      end
      WRITE: begin
        hit_d   = (board_q == GOAL);
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      board_q <= '0;
      ord_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      ord_q   <= ord_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.wb_we   = (state_q == WRITE);
  assign bus.err     = err_q;
  assign bus.hit     = hit_q;
  assign bus.wb_dst  = DST_REG;
  assign bus.wb_data = board_q;

endmodule

// File: tb/tb_slide_engine.sv
module tb_slide_engine;
  localparam logic [39:0] GOAL = 40'h8123456780;
  localparam logic [39:0] BA   = 40'h5123450786;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slide_engine_if bus ();
  slide_engine #(.DST_REG(4'd2), .GOAL(GOAL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // observations from the most recent run
  int          r_we_cyc, r_we_cnt, r_done_cyc;
  logic [39:0] r_wdat, r_ddat;
  logic        r_err, r_hit, r_busy_after, r_err_after;

  // New blank position after move m from blank b, or -1 if the move leaves the 3x3 grid.
  function automatic int step(input int b, input int m);
    int row, col;
    row = b / 3;
    col = b % 3;
    case (m)
      0: step = (row > 0) ? b - 3 : -1;
      1: step = (row < 2) ? b + 3 : -1;
      2: step = (col > 0) ? b - 1 : -1;
      default: step = (col < 2) ? b + 1 : -1;
    endcase
  endfunction

  // Reference: final board, error flag and the cycle (after E0) in which done is expected.
  function automatic void model(input logic [39:0] bin, input logic [33:0] o,
                                output logic [39:0] fb, output logic e, output int dcyc);
    int tiles[9];
    int b, d, nb, m;
    b = int'(bin[39:36]);
    d = int'(o[33:30]);
    fb = bin;
    e = 1'b0;
    dcyc = d + 1;
    if (b > 8) begin
      e = 1'b1;
      dcyc = 0;
      return;
    end
    for (int p = 0; p < 9; p++) tiles[p] = int'(bin[35-4*p -: 4]);
    for (int k = 0; k < d; k++) begin
      m = int'((o >> (28 - 2*k)) & 34'd3);
      nb = step(b, m);
      if (nb < 0) begin
        e = 1'b1;
        dcyc = k + 1;
        break;
      end
      tiles[b] = tiles[nb];
      tiles[nb] = 0;
      b = nb;
    end
    fb[39:36] = 4'(b);
    for (int p = 0; p < 9; p++) fb[35-4*p -: 4] = 4'(tiles[p]);
  endfunction

  // Issue one start and observe the run; optionally re-assert start at cycle poke_at.
  task automatic run_op(input logic [39:0] b, input logic [33:0] o, input int poke_at,
                        input logic [39:0] pb, input logic [33:0] po);
    @(negedge clk);
    bus.start = 1'b1;
    bus.board_in = b;
    bus.ord_in = o;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    r_we_cyc = -1; r_we_cnt = 0; r_done_cyc = -1;
    r_wdat = '0; r_ddat = '0; r_err = 1'b0; r_hit = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      if (bus.wb_we) begin
        r_we_cnt++;
        if (r_we_cyc < 0) r_we_cyc = n;
        r_wdat = bus.wb_data;
      end
      if (bus.done) begin
        r_done_cyc = n;
        r_ddat = bus.wb_data;
        r_err = bus.err;
        r_hit = bus.hit;
        break;
      end
      if (n == poke_at) begin
        bus.start = 1'b1;
        bus.board_in = pb;
        bus.ord_in = po;
      end
    end
    @(posedge clk);
    #1;
    r_busy_after = bus.busy;
    r_err_after = bus.err;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", bus.err); end
    checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b want=0", bus.hit); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", bus.wb_we); end
    checks++; if (bus.wb_data !== 40'h0) begin errors++; $display("FAIL reset_data got=%h want=0", bus.wb_data); end
    checks++; if (bus.wb_dst !== 4'd2) begin errors++; $display("FAIL reset_dst got=%h want=2", bus.wb_dst); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_move;
    run_op(BA, 34'h050000000, -1, '0, '0);
    checks++; if (r_we_cyc !== 1) begin errors++; $display("FAIL single_we_cycle got=%0d want=1", r_we_cyc); end
    checks++; if (r_we_cnt !== 1) begin errors++; $display("FAIL single_we_count got=%0d want=1", r_we_cnt); end
    checks++; if (r_wdat !== GOAL) begin errors++; $display("FAIL single_wdata got=%h want=%h", r_wdat, GOAL); end
    checks++; if (r_done_cyc !== 2) begin errors++; $display("FAIL single_done_cycle got=%0d want=2", r_done_cyc); end
    checks++; if ({r_err, r_hit} !== 2'b01) begin errors++; $display("FAIL single_err_hit got=%b%b want=01", r_err, r_hit); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b want=0", r_busy_after); end
    checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL single_hit_held got=%b want=1", bus.hit); end
  endtask

  task automatic test_illegal;
    run_op(BA, 34'h070000000, -1, '0, '0);
    checks++; if (r_we_cnt !== 0) begin errors++; $display("FAIL illegal_we_count got=%0d want=0", r_we_cnt); end
    checks++; if (r_done_cyc !== 1) begin errors++; $display("FAIL illegal_done_cycle got=%0d want=1", r_done_cyc); end
    checks++; if ({r_err, r_hit} !== 2'b10) begin errors++; $display("FAIL illegal_err_hit got=%b%b want=10", r_err, r_hit); end
    checks++; if (r_ddat !== BA) begin errors++; $display("FAIL illegal_board got=%h want=%h", r_ddat, BA); end
    checks++; if (r_err_after !== 1'b1) begin errors++; $display("FAIL illegal_err_held got=%b want=1", r_err_after); end
  endtask

  task automatic test_cancel;
    run_op(BA, 34'h090000000, -1, '0, '0);
    checks++; if (r_we_cyc !== 2) begin errors++; $display("FAIL cancel_we_cycle got=%0d want=2", r_we_cyc); end
    checks++; if (r_done_cyc !== 3) begin errors++; $display("FAIL cancel_done_cycle got=%0d want=3", r_done_cyc); end
    checks++; if (r_wdat !== BA) begin errors++; $display("FAIL cancel_wdata got=%h want=%h", r_wdat, BA); end
    checks++; if ({r_err, r_hit} !== 2'b00) begin errors++; $display("FAIL cancel_err_hit got=%b%b want=00", r_err, r_hit); end
  endtask

  task automatic test_zero_depth_bad_blank;
    run_op(BA, 34'h000000000, -1, '0, '0);
    checks++; if (r_we_cyc !== 0) begin errors++; $display("FAIL zero_we_cycle got=%0d want=0", r_we_cyc); end
    checks++; if (r_wdat !== BA) begin errors++; $display("FAIL zero_wdata got=%h want=%h", r_wdat, BA); end
    checks++; if (r_done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle got=%0d want=1", r_done_cyc); end
    run_op(GOAL, 34'h000000000, -1, '0, '0);
    checks++; if (r_hit !== 1'b1) begin errors++; $display("FAIL zero_goal_hit got=%b want=1", r_hit); end
    run_op(40'hF000000000, 34'h050000000, -1, '0, '0);
    checks++; if (r_done_cyc !== 0) begin errors++; $display("FAIL badblank_done_cycle got=%0d want=0", r_done_cyc); end
    checks++; if (r_we_cnt !== 0) begin errors++; $display("FAIL badblank_we_count got=%0d want=0", r_we_cnt); end
    checks++; if ({r_err, r_hit} !== 2'b10) begin errors++; $display("FAIL badblank_err_hit got=%b%b want=10", r_err, r_hit); end
  endtask

  task automatic test_start_busy;
    run_op(BA, 34'h090000000, 0, GOAL, 34'h000000000);
    checks++; if (r_we_cyc !== 2) begin errors++; $display("FAIL busy_start_we_cycle got=%0d want=2", r_we_cyc); end
    checks++; if (r_wdat !== BA) begin errors++; $display("FAIL busy_start_wdata got=%h want=%h", r_wdat, BA); end
    checks++; if (r_done_cyc !== 3) begin errors++; $display("FAIL busy_start_done_cycle got=%0d want=3", r_done_cyc); end
    checks++; if (r_hit !== 1'b0) begin errors++; $display("FAIL busy_start_hit got=%b want=0", r_hit); end
  endtask

  task automatic test_reset_mid_run;
    logic [33:0] o;
    int we_seen, done_seen;
    o = '0;
    o[33:30] = 4'd15;
    for (int k = 0; k < 15; k++) o[29-2*k -: 2] = (k % 2 == 0) ? 2'b00 : 2'b01;
    @(negedge clk);
    bus.start = 1'b1; bus.board_in = GOAL; bus.ord_in = o;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b want=0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    we_seen = 0; done_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.wb_we) we_seen++;
      if (bus.done) done_seen++;
    end
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL midreset_writes got=%0d want=0", we_seen); end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midreset_done got=%0d want=0", done_seen); end
    checks++; if (bus.wb_data !== 40'h0) begin errors++; $display("FAIL midreset_board got=%h want=0", bus.wb_data); end
  endtask

  // Random permuted boards and move lists (mostly legal), checked against the reference model.
  task automatic test_random;
    int perm[9];
    int t, j, b, d, m, nb;
    logic [39:0] bin, fb;
    logic [33:0] o;
    logic e;
    int dcyc;
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 9; p++) perm[p] = p;
      for (int p = 8; p > 0; p--) begin
        j = $urandom_range(0, p);
        t = perm[p]; perm[p] = perm[j]; perm[j] = t;
      end
      b = 0;
      for (int p = 0; p < 9; p++) begin
        bin[35-4*p -: 4] = 4'(perm[p]);
        if (perm[p] == 0) b = p;
      end
      bin[39:36] = 4'(b);
      if ($urandom_range(0, 9) == 0) bin[39:36] = 4'($urandom_range(9, 15));
      d = $urandom_range(0, 15);
      o = 34'($urandom) ^ (34'($urandom) << 2);
      o[33:30] = 4'(d);
      for (int k = 0; k < d; k++) begin
        m = $urandom_range(0, 3);
        if ($urandom_range(0, 19) != 0) begin
          for (int tries = 0; tries < 8 && step(b, m) < 0; tries++) m = $urandom_range(0, 3);
        end
        o[29-2*k -: 2] = 2'(m);
        nb = step(b, m);
        if (nb >= 0) b = nb;
      end
      model(bin, o, fb, e, dcyc);
      run_op(bin, o, -1, '0, '0);
      checks++; if (r_done_cyc !== dcyc) begin errors++; $display("FAIL rand%0d_done_cycle got=%0d want=%0d", it, r_done_cyc, dcyc); end
      checks++; if (r_err !== e) begin errors++; $display("FAIL rand%0d_err got=%b want=%b", it, r_err, e); end
      checks++; if (r_we_cnt !== (e ? 0 : 1)) begin errors++; $display("FAIL rand%0d_we_count got=%0d want=%0d", it, r_we_cnt, e ? 0 : 1); end
      checks++; if (!e && (r_we_cyc !== d || r_wdat !== fb)) begin errors++; $display("FAIL rand%0d_write got=%0d/%h want=%0d/%h", it, r_we_cyc, r_wdat, d, fb); end
      checks++; if (r_ddat !== fb) begin errors++; $display("FAIL rand%0d_board got=%h want=%h", it, r_ddat, fb); end
      checks++; if (r_hit !== (!e && fb == GOAL)) begin errors++; $display("FAIL rand%0d_hit got=%b want=%b", it, r_hit, (!e && fb == GOAL)); end
      checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL rand%0d_busy_after got=%b want=0", it, r_busy_after); end
    end
  endtask

  // Second start lands in the first idle cycle after done and must be accepted.
  task automatic test_back_to_back;
    run_op(BA, 34'h050000000, -1, '0, '0);
    run_op(GOAL, 34'h040000000, -1, '0, '0);
    checks++; if (r_we_cyc !== 1) begin errors++; $display("FAIL b2b_we_cycle got=%0d want=1", r_we_cyc); end
    checks++; if (r_wdat !== 40'h5123450786) begin errors++; $display("FAIL b2b_wdata got=%h want=5123450786", r_wdat); end
    checks++; if (r_done_cyc !== 2) begin errors++; $display("FAIL b2b_done_cycle got=%0d want=2", r_done_cyc); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.board_in = '0;
    bus.ord_in = '0;
    test_reset();
    test_single_move();
    test_illegal();
    test_cancel();
    test_zero_depth_bad_blank();
    test_start_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/slide_engine.md
# slide_engine

Move-execution stage that sits directly upstream of the 8-puzzle register file. It takes a board word and a move-order word (depth plus up to 15 two-bit moves) and applies the moves one per clock. When all moves have been applied, it writes the resulting board back through the register file's write port (we/dst/data). It also flags illegal moves and reports whether the result matches the goal board.

## Interface
Parameters:
- DST_REG, 4'd2: register-file index written with the result (temp board slot).
- GOAL, 40'h8123456780: solved board used for the hit compare.

Ports (reset rst_n is synchronous, active-low; clock is clk):
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- board_in  in  40  starting board.
- ord_in  in  34  move order.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  illegal move or bad blank index; valid while done=1, held until the next start.
- hit  out  1  working board == GOAL; valid while done=1, held until the next start.
- wb_we  out  1  register-file write enable.
- wb_dst  out  4  constant DST_REG.
- wb_data  out  40  working board; always driven.

## Operation
Board format:
- [39:36] = blank position b (0..8).
- Tile at position p occupies [35-4p:32-4p]; the blank's nibble is 0.
- Position p has row p/3 and column p%3.

Order format:
- [33:30] = depth d (0..15).
- Move k (k = 0..d-1) occupies [29-2k:28-2k]; move 0 is applied first.
- Bits above move d-1 are ignored.

Move codes (direction the blank moves), with legality and new blank position b':
- 00 up: legal if b ≥ 3; b' = b-3.
- 01 down: legal if b ≤ 5; b' = b+3.
- 10 left: legal if b%3 ≠ 0; b' = b-1.
- 11 right: legal if b%3 ≠ 2; b' = b+1.

Applying a legal move:
- The tile at b' is copied into nibble b.
- Nibble b' is set to 0.
- [39:36] is set to b'.
- All other nibbles are unchanged.

FSM states: IDLE, RUN, WRITE, DONE.
- IDLE, start=1: latch board_in into the working board and ord_in into the order register; clear cnt, err and hit.
  - If board_in[39:36] > 8: set err and go to DONE.
  - Else if d == 0: go to WRITE.
  - Else: go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN: evaluate move cnt against the current board.
  - Illegal: set err, leave the board unchanged, go to DONE (no write).
  - Legal: update the board and increment cnt; go to WRITE when cnt+1 == d.
- WRITE: wb_we=1 for exactly one cycle with wb_data = final board. Register hit = (board == GOAL). Go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.

Rules:
- start while busy is ignored, with no effect on the run in progress.
- cnt is 4 bits and never wraps, because d ≤ 15 is checked before the increment.
- hit is evaluated only in WRITE and reads 0 after an error.

## Timing
- Reset values: state IDLE; busy=0, done=0, err=0, hit=0, wb_we=0; working board = 0; wb_dst = DST_REG.
- Reset asserted in any state returns the FSM to IDLE on the next edge. No write is issued, and no done pulse is produced for the aborted run.
- Latency, counting start sampled at edge E0:
  - Move k is applied at edge E(k+1).
  - wb_we is high in the cycle after edge Ed.
  - done is high in the cycle after edge E(d+1).
  - busy falls after edge E(d+2).
- d = 0: wb_we is high in the cycle after E0 and done after E1.
- Illegal move k: the err transition happens at edge E(k+1), done follows in the next cycle, and wb_we never asserts.
- Bad blank index: done is high in the cycle after E0.
- A new start is accepted in the first IDLE cycle after done, giving back-to-back runs with one idle cycle between.

## Test plan
- Single legal move: start, board_in=40'h5123450786, ord_in=34'h050000000 (d=1, down). Required: wb_we one cycle with wb_data=40'h8123456780, then done with hit=1 and err=0.
- Illegal move: same board, ord_in=34'h070000000 (d=1, right with b=5). Required: done with err=1; wb_we never asserts; wb_data stays 40'h5123450786.
- Two moves that cancel: ord_in=34'h090000000 (d=2, down then up). Required: wb_data=40'h5123450786 and hit=0; wb_we in the cycle after E2, done in the cycle after E3.
- Zero depth and bad blank: d=0 gives a write of board_in in the cycle after E0. board_in=40'hF000000000 gives err=1 and done in the cycle after E0, with no write.
- Start while busy: assert start again during RUN with a different board. Required: ignored; the first run's result is written unchanged.
- Reset mid-run: assert rst_n=0 during RUN of a d=15 order. Required: the FSM returns to IDLE with busy=0, with no write and no done pulse.
